// File: rtl/cskip_sub_serial_pkg.sv
// Shared definitions for the digit-serial carry-skip subtractor.
//   state_t     : FSM state encoding (IDLE / RUN / DONE, 2 bits)
//   DIGIT_DEF   : default digit (carry-skip cell) width
//   num_digits(): number of digit slices needed to cover a word
package cskip_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_DEF = 4;

  function automatic int num_digits(input int width, input int digit);
    return (width + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/cskip_sub_serial_digit.sv
// Carry-skip digit cell: DIGIT-bit ripple adder whose carry-out bypasses the
// ripple chain when every lane propagates.
//   sum  : out DIGIT  a + b + cin (low DIGIT bits)
//   cout : out 1      carry out of the cell
//   a, b : in  DIGIT  addends
//   cin  : in  1      carry in
module cskip_digit #(
  parameter int DIGIT = 4
) (
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin
);

  logic [DIGIT-1:0] p;
  logic             rc;

  assign p = a ^ b;

  always_comb begin
    sum = '0;
    rc  = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i] = p[i] ^ rc;
      rc     = (a[i] & b[i]) | (p[i] & rc);
    end
  end

  // Group propagate: if all lanes propagate, cin passes straight through.
  assign cout = (&p) ? cin : rc;

endmodule

// File: rtl/cskip_sub_serial.sv
// Digit-serial subtractor: o_diff = i_minuend - i_subtrahend mod 2^WIDTH and an
// unsigned borrow flag. One DIGIT-wide slice per clock, LSB slice first, via
// a single carry-skip cell computing A + ~B + 1.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_valid / o_ready   : operand handshake (o_ready high only in IDLE)
//   i_minuend           : A
//   i_subtrahend        : B
//   o_valid / i_ready   : result handshake (o_valid high only in DONE)
//   o_diff              : A - B mod 2^WIDTH
//   o_borrow            : 1 iff A < B (unsigned)
module cskip_sub_serial
  import cskip_pkg::*;
#(
  parameter int WIDTH = 43,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int ND   = num_digits(WIDTH, DIGIT);
  localparam int PW   = ND * DIGIT;             // operand width padded to whole slices
  localparam int IW   = (ND > 1) ? $clog2(ND) : 1;
  localparam int REM  = WIDTH % DIGIT;
  localparam int TOPB = (REM == 0) ? 0 : REM;   // first padded lane of the top slice
  localparam logic [IW-1:0] LAST = IW'(ND - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [PW-1:0]    a_q, bn_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, valid_q, ready_q;

  logic [WIDTH-1:0] sub_n;
  logic [DIGIT-1:0] a_sl, b_sl, sum;
  logic             cout, cout_top;

  assign sub_n = ~i_subtrahend;

  // Padded lanes hold 0 in both operands (zero-extended at accept).
  assign a_sl = a_q[int'(idx) * DIGIT +: DIGIT];
  assign b_sl = bn_q[int'(idx) * DIGIT +: DIGIT];

  cskip_digit #(.DIGIT(DIGIT)) u_digit (
    .sum  (sum),
    .cout (cout),
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry)
  );

  // With a partial top slice the carry out of bit WIDTH-1 lands in the first
  // padded lane, whose operand bits are 0, so its sum bit is that carry.
  assign cout_top = (REM != 0 && idx == LAST) ? sum[TOPB] : cout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      bn_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          a_q     <= PW'(i_minuend);
          bn_q    <= PW'(sub_n);
          carry   <= 1'b1;
          idx     <= '0;
          diff_q  <= '0;
          ready_q <= 1'b0;
          state   <= RUN;
        end
        RUN: begin
          // Bit-wise write so padded lanes of the top slice never reach diff.
          for (int i = 0; i < DIGIT; i++)
            if (int'(idx) * DIGIT + i < WIDTH)
              diff_q[int'(idx) * DIGIT + i] <= sum[i];
          carry <= cout_top;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            borrow_q <= ~cout_top;
            valid_q  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: if (i_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;

endmodule
